// File: rtl/shift_pattern_gen_pkg.sv
// Shared mode/direction encodings for the walking-pattern generator.
package shift_gen_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROTL   = 2'b01;
    localparam logic [1:0] MODE_ROTR   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_pattern_gen_dwell_timer.sv
// Per-direction dwell counter; step is combinational and asserts on the last dwell cycle.
// No backpressure: clr wins over en, and en=0 freezes the count.
module dwell_timer
    import shift_gen_pkg::*;
#(
    parameter int DWELL_L = 4,
    parameter int DWELL_R = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic dir,
    input  logic clr,
    output logic step
);

    localparam int DCNT_W = $clog2(max_int(DWELL_L, DWELL_R) + 1);

    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dwell_m1;

    // Dwell length follows dir as it stands, so a mode change never restarts a position.
    assign dwell_m1 = (dir == DIR_DN) ? DCNT_W'(DWELL_R - 1) : DCNT_W'(DWELL_L - 1);
    assign step     = en && (dcnt >= dwell_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt <= '0;
        end else if (clr) begin
            dcnt <= '0;
        end else if (en) begin
            if (step) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_pattern_gen.sv
// Walking-pattern generator (bounce/rotate/hold); count/dir/wrap registered, one cycle after final dwell.
// No backpressure: en=0 or hold mode freezes state. PATTERN_LOAD_EN adds load/load_val.
module shift_pattern_gen
    import shift_gen_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_L = 4,
    parameter int DWELL_R = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
`ifdef PATTERN_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             wrap
);

    logic             load_q;
    logic [WIDTH-1:0] load_pat;
    logic             adv;
    logic             step;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_nxt;
    logic             wrap_nxt;

`ifdef PATTERN_LOAD_EN
    assign load_q   = load;
    // An all-zero pattern would never move, so it is replaced by bit0.
    assign load_pat = (load_val == '0) ? WIDTH'(1) : load_val;
`else
    assign load_q   = 1'b0;
    assign load_pat = WIDTH'(1);
`endif

    assign adv = en && (mode != MODE_HOLD) && !load_q;

    dwell_timer #(
        .DWELL_L (DWELL_L),
        .DWELL_R (DWELL_R)
    ) u_dwell_timer (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .dir   (dir),
        .clr   (load_q),
        .step  (step)
    );

    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        wrap_nxt  = 1'b0;
        if (load_q) begin
            count_nxt = load_pat;
        end else if (step) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (count[WIDTH-1]) begin
                            dir_nxt   = DIR_DN;
                            count_nxt = count >> 1;
                            wrap_nxt  = 1'b1;
                        end else begin
                            count_nxt = count << 1;
                        end
                    end else begin
                        if (count[0]) begin
                            dir_nxt   = DIR_UP;
                            count_nxt = count << 1;
                            wrap_nxt  = 1'b1;
                        end else begin
                            count_nxt = count >> 1;
                        end
                    end
                end
                MODE_ROTL: begin
                    count_nxt = {count[WIDTH-2:0], count[WIDTH-1]};
                    dir_nxt   = DIR_UP;
                    wrap_nxt  = count[WIDTH-1];
                end
                MODE_ROTR: begin
                    count_nxt = {count[0], count[WIDTH-1:1]};
                    dir_nxt   = DIR_DN;
                    wrap_nxt  = count[0];
                end
                default: begin
                    count_nxt = count;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= WIDTH'(1);
            dir   <= DIR_UP;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            dir   <= dir_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_shift_pattern_gen.sv
// Vector table for shift_pattern_gen (WIDTH=8, DWELL_L=4, DWELL_R=1) with expected-result queue.
module tb_shift_pattern_gen;
    import shift_gen_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic         rst;
        logic         en;
        logic [1:0]   mode;
        logic         ld;
        logic [W-1:0] ld_val;
        logic [W-1:0] cnt;
        logic         dir;
        logic         wrap;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic         dir;
        logic         wrap;
        int           idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = MODE_BOUNCE;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         dir;
    logic         wrap;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_pattern_gen #(
        .WIDTH   (W),
        .DWELL_L (4),
        .DWELL_R (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
`ifdef PATTERN_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count),
        .dir      (dir),
        .wrap     (wrap)
    );

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [W-1:0] c, input logic d, input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.ld = 1'b0; v.ld_val = '0;
        v.cnt = c; v.dir = d; v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic rep(input int n, input logic e, input logic [1:0] m,
                       input logic [W-1:0] c, input logic d);
        for (int k = 0; k < n; k++) add(1'b0, e, m, c, d, 1'b0);
    endtask

    task automatic add_ld(input logic r, input logic e, input logic [W-1:0] lv,
                          input logic [W-1:0] c, input logic d);
        vec_t v;
        v.rst = r; v.en = e; v.mode = MODE_BOUNCE; v.ld = 1'b1; v.ld_val = lv;
        v.cnt = c; v.dir = d; v.wrap = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic check_field(input string name, input int idx, input logic [W-1:0] act,
                               input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic build_table();
        logic [W-1:0] one;
        one = W'(1);
        // reset held with en=1
        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, MODE_BOUNCE, 8'h01, 1'b0, 1'b0);
        // bounce up with 4-cycle dwell, fast descent, reversal at 80 and 01
        rep(3, 1'b1, MODE_BOUNCE, 8'h01, 1'b0);
        for (int p = 1; p < 8; p++) rep(4, 1'b1, MODE_BOUNCE, one << p, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h40, 1'b1, 1'b1);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h20, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h10, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h08, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h04, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h01, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b0, 1'b1);
        rep(3, 1'b1, MODE_BOUNCE, 8'h02, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h04, 1'b0, 1'b0);
        // climb back to 80, then rotate-left wraps 80 -> 01
        rep(3, 1'b1, MODE_BOUNCE, 8'h04, 1'b0);
        for (int p = 3; p < 7; p++) rep(4, 1'b1, MODE_BOUNCE, one << p, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h80, 1'b0, 1'b0);
        rep(3, 1'b1, MODE_ROTL, 8'h80, 1'b0);
        add(1'b0, 1'b1, MODE_ROTL, 8'h01, 1'b0, 1'b1);
        rep(3, 1'b1, MODE_ROTL, 8'h01, 1'b0);
        add(1'b0, 1'b1, MODE_ROTL, 8'h02, 1'b0, 1'b0);
        // switch to rotate-right mid-dwell: dwell continues, then steps right
        add(1'b0, 1'b1, MODE_ROTL, 8'h02, 1'b0, 1'b0);
        rep(2, 1'b1, MODE_ROTR, 8'h02, 1'b0);
        add(1'b0, 1'b1, MODE_ROTR, 8'h01, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_ROTR, 8'h80, 1'b1, 1'b1);
        add(1'b0, 1'b1, MODE_ROTR, 8'h40, 1'b1, 1'b0);
        // bounce down to 01, reverse
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h20, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h10, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h08, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h04, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h01, 1'b1, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b0, 1'b1);
        // en=0 for 5 cycles mid-dwell; remaining two dwell cycles then step
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b0, 1'b0);
        rep(5, 1'b0, MODE_BOUNCE, 8'h02, 1'b0);
        rep(2, 1'b1, MODE_BOUNCE, 8'h02, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h04, 1'b0, 1'b0);
        // hold mode freezes the same way
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h04, 1'b0, 1'b0);
        rep(3, 1'b1, MODE_HOLD, 8'h04, 1'b0);
        rep(2, 1'b1, MODE_BOUNCE, 8'h04, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h08, 1'b0, 1'b0);
        // reset mid-dwell clears dwell: full 4-cycle hold at 01 afterwards
        rep(2, 1'b1, MODE_BOUNCE, 8'h08, 1'b0);
        add(1'b1, 1'b1, MODE_BOUNCE, 8'h01, 1'b0, 1'b0);
        rep(3, 1'b1, MODE_BOUNCE, 8'h01, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h02, 1'b0, 1'b0);
`ifdef PATTERN_LOAD_EN
        add_ld(1'b0, 1'b0, 8'h03, 8'h03, 1'b0);
        rep(3, 1'b1, MODE_BOUNCE, 8'h03, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h06, 1'b0, 1'b0);
        add_ld(1'b0, 1'b1, 8'h00, 8'h01, 1'b0);
        add_ld(1'b0, 1'b1, 8'hC0, 8'hC0, 1'b0);
        rep(3, 1'b1, MODE_BOUNCE, 8'hC0, 1'b0);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h60, 1'b1, 1'b1);
        add(1'b0, 1'b1, MODE_BOUNCE, 8'h30, 1'b1, 1'b0);
        add_ld(1'b1, 1'b1, 8'h55, 8'h01, 1'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            en       = vecs[i].en;
            mode     = vecs[i].mode;
            load     = vecs[i].ld;
            load_val = vecs[i].ld_val;
            e.cnt = vecs[i].cnt; e.dir = vecs[i].dir; e.wrap = vecs[i].wrap; e.idx = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", i);
            end else begin
                e = sb.pop_front();
                check_field("count", e.idx, count, e.cnt);
                check_field("dir", e.idx, W'(dir), W'(e.dir));
                check_field("wrap", e.idx, W'(wrap), W'(e.wrap));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
